snake_step_ctrl: RTL
====================

Name: snake_step_ctrl

Overview:
Sequences snake head movement for the game. Takes the registered 2-bit direction from the button-input block, filters illegal 180° reversals, and produces fixed-rate step ticks from a prescaler. Updates the head coordinate on each tick and runs the game state machine. Downstream body/render logic consumes the `step` pulse and head position, and returns a self-collision flag.

Parameters:
TICK_DIV, 10000000, clock cycles per movement step (10 steps/s at 100 MHz); must be >= 2
GRID_W, 40, playfield width in cells
GRID_H, 30, playfield height in cells
X_W, 6, width of head_x; must satisfy 2^X_W >= GRID_W
Y_W, 5, width of head_y; must satisfy 2^Y_W >= GRID_H
START_X, 20, head x after reset/restart
START_Y, 15, head y after reset/restart

Ports:
CLK_100MHz  input  1  system clock, all logic rising-edge
Reset  input  1  synchronous, active-high reset
dir_in  input  2  requested direction: 00 Up, 01 Right, 10 Down, 11 Left
start  input  1  level; IDLE->RUN and DEAD->IDLE
pause  input  1  level; hold in PAUSE while high
hit  input  1  self-collision from body logic, valid any cycle
head_x  output  X_W  current head column
head_y  output  Y_W  current head row (0 = top)
heading  output  2  committed direction, same encoding as dir_in
step  output  1  one-cycle pulse; head_x/head_y/heading updated in same cycle
game_over  output  1  high while in DEAD
state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DEAD

Behaviour:
- Reset (sync, priority over everything):
  - state=IDLE, head=(START_X,START_Y), heading=01, pend_dir=01, cnt=0, step=0, game_over=0.
- pend_dir:
  - Register updated every cycle in IDLE and RUN with dir_in.
  - Update is skipped when (dir_in XOR heading)==2'b10 (reversal).
  - Frozen in PAUSE and DEAD.
- Prescaler cnt (width ceil(log2(TICK_DIV))):
  - Increments only in RUN.
  - When cnt==TICK_DIV-1 in RUN, cnt<=0 and a step event occurs on that edge.
- Step event:
  - heading<=pend_dir.
  - Head moves one cell in pend_dir: Up y-1, Down y+1, Left x-1, Right x+1.
  - step=1 for exactly that one registered cycle; otherwise 0.
  - Tick-to-step latency is 1 cycle; head, heading and step change together.
- Reversal check uses the committed heading, not pend_dir. A Right->Up->Left sequence within one tick period therefore leaves pend_dir=Up.
- Wall (no WRAP_EN): a step that would leave 0..GRID_W-1 or 0..GRID_H-1 instead causes:
  - state<=DEAD, game_over<=1, step stays 0.
  - head and heading hold their pre-step values.
- FSM:
  - IDLE: start=1 -> RUN with cnt=0.
  - RUN:
    - hit=1 -> DEAD. Highest priority: overrides a coincident tick, and no step is issued.
    - Otherwise pause=1 -> PAUSE; cnt holds, and a coincident tick is deferred.
  - PAUSE: pause=0 -> RUN; counting resumes from the held cnt. hit is ignored in PAUSE.
  - DEAD: start=1 -> IDLE. head, heading, pend_dir and cnt reload their reset values; game_over<=0.
- start held continuously: DEAD->IDLE->RUN on consecutive cycles (legal).
- hit is ignored in IDLE and DEAD.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
SNAKE_WRAP_EN
- Defined: leaving an edge wraps to the opposite edge, with no DEAD transition.
  - x: 0 -> GRID_W-1 and GRID_W-1 -> 0.
  - y: 0 -> GRID_H-1 and GRID_H-1 -> 0.
  - step pulses normally.
- Undefined: wall collision -> DEAD as described in Behaviour. Only hit and wall collisions end the game.

Test Plan:
- TICK_DIV=4, reset, start=1 at cycle 0, dir_in=01 -> first step 4 cycles after entering RUN; head (21,15); then one step every 4 cycles; step exactly 1 cycle wide.
- heading=01, dir_in=11 held for 3 ticks -> heading stays 01, x increments each tick; then dir_in=00 -> next step heading=00, y=14.
- Within one tick apply dir_in 00 then 11 -> step commits 00 (the 11 is rejected against heading 01); the following tick may commit 11.
- Head at (39,15) heading 01, tick: without macro -> state=11, game_over=1, head stays (39,15), no step; with SNAKE_WRAP_EN -> head (0,15), step=1.
- In RUN at cnt=2 (TICK_DIV=4), pause=1 for 10 cycles -> state=10, no step, cnt held; pause=0 -> step 2 cycles after RUN resumes.
- hit=1 coincident with the tick cycle -> DEAD, no step, head unchanged; start=1 -> IDLE with head (20,15), heading 01, game_over=0; Reset mid-RUN -> all reset values on the next edge.

Source files
------------

// File: rtl/snake_step_ctrl.sv
// Snake head stepper: reversal-filtered direction, step prescaler, game FSM.
// Define SNAKE_WRAP_EN to wrap the head at the playfield edges instead of dying.
module snake_step_ctrl #(
    parameter int TICK_DIV = 10000000,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int X_W      = 6,
    parameter int Y_W      = 5,
    parameter int START_X  = 20,
    parameter int START_Y  = 15
) (
    input  logic           CLK_100MHz,
    input  logic           Reset,
    input  logic [1:0]     dir_in,
    input  logic           start,
    input  logic           pause,
    input  logic           hit,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [1:0]     heading,
    output logic           step,
    output logic           game_over,
    output logic [1:0]     state
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DEAD  = 2'b11
    } state_e;

    state_e         state_q;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic [1:0]     heading_q;
    logic [1:0]     pend_q;
    logic [CW-1:0]  cnt_q;
    logic           step_q;
    logic           over_q;

    logic [X_W-1:0] x_d;
    logic [Y_W-1:0] y_d;
    logic           wall_d;
    logic           tick_d;
    logic           rev_d;

    assign tick_d = (cnt_q == CW'(TICK_DIV - 1));
    // Reversal is judged against the committed heading, not the pending one.
    assign rev_d  = ((dir_in ^ heading_q) == 2'b10);

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        wall_d = 1'b0;
        unique case (pend_q)
            2'b00: begin
                if (y_q == '0) begin
`ifdef SNAKE_WRAP_EN
                    y_d = Y_W'(GRID_H - 1);
`else
                    wall_d = 1'b1;
`endif
                end else begin
                    y_d = y_q - Y_W'(1);
                end
            end
            2'b01: begin
                if (x_q == X_W'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
                    x_d = '0;
`else
                    wall_d = 1'b1;
`endif
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
            2'b10: begin
                if (y_q == Y_W'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
                    y_d = '0;
`else
                    wall_d = 1'b1;
`endif
                end else begin
                    y_d = y_q + Y_W'(1);
                end
            end
            default: begin
                if (x_q == '0) begin
`ifdef SNAKE_WRAP_EN
                    x_d = X_W'(GRID_W - 1);
`else
                    wall_d = 1'b1;
`endif
                end else begin
                    x_d = x_q - X_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK_100MHz) begin
        if (Reset) begin
            state_q   <= IDLE;
            x_q       <= X_W'(START_X);
            y_q       <= Y_W'(START_Y);
            heading_q <= 2'b01;
            pend_q    <= 2'b01;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            step_q <= 1'b0;
            if ((state_q == IDLE || state_q == RUN) && !rev_d) begin
                pend_q <= dir_in;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    if (hit) begin
                        state_q <= DEAD;
                        over_q  <= 1'b1;
                    end else if (pause) begin
                        state_q <= PAUSE;
                    end else if (tick_d) begin
                        cnt_q <= '0;
                        if (wall_d) begin
                            state_q <= DEAD;
                            over_q  <= 1'b1;
                        end else begin
                            x_q       <= x_d;
                            y_q       <= y_d;
                            heading_q <= pend_q;
                            step_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_q <= RUN;
                    end
                end
                DEAD: begin
                    if (start) begin
                        state_q   <= IDLE;
                        x_q       <= X_W'(START_X);
                        y_q       <= Y_W'(START_Y);
                        heading_q <= 2'b01;
                        pend_q    <= 2'b01;
                        cnt_q     <= '0;
                        over_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign head_x    = x_q;
    assign head_y    = y_q;
    assign heading   = heading_q;
    assign step      = step_q;
    assign game_over = over_q;
    assign state     = state_q;

endmodule
